// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-rate divider: channel modes and the
// channel-index width rule.
package div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Width of a channel index; a single-channel build still gets a 1-bit select.
  function automatic int CH_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, active divisor/mode and a shadow that is
// applied only at terminal count (or SYNC) so period changes never glitch.
module div_channel
  import div_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 20000,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SYNC,
  input  logic             WR,
  input  logic [CNT_W-1:0] WR_DIV,
  input  logic             WR_MODE,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             PENDING
);

  logic [CNT_W-1:0] q, q_n;
  logic [CNT_W-1:0] div_r, div_n;
  logic [CNT_W-1:0] shadow_div, shadow_div_n;
  mode_e            mode_r, mode_n;
  mode_e            shadow_mode, shadow_mode_n;
  logic             pending_r, pending_n;
  logic             clk_out_r, clk_out_n;
  logic             tick_r, tick_n;
  logic             tc;

  assign tc = EN && (q == div_r);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    div_n         = div_r;
    mode_n        = mode_r;
    shadow_div_n  = shadow_div;
    shadow_mode_n = shadow_mode;
    pending_n     = pending_r;

    // A write landing on the apply edge bypasses the shadow entirely.
    if (tc || SYNC) begin
      if (WR) begin
        div_n  = WR_DIV;
        mode_n = mode_e'(WR_MODE);
      end else if (pending_r) begin
        div_n  = shadow_div;
        mode_n = shadow_mode;
      end
      pending_n = 1'b0;
    end else if (WR) begin
      shadow_div_n  = WR_DIV;
      shadow_mode_n = mode_e'(WR_MODE);
      pending_n     = 1'b1;
    end

    if (SYNC || tc) begin
      q_n = '0;
    end else if (EN) begin
      q_n = q + CNT_W'(1);
    end else begin
      q_n = q;
    end

    tick_n = tc && !SYNC;

    // The mode in force after this edge decides the output, so a switch to
    // pulse mode follows TICK from the apply edge itself.
    if (SYNC) begin
      clk_out_n = 1'b0;
    end else if (mode_n == MODE_PULSE) begin
      clk_out_n = tc;
    end else if (tc) begin
      clk_out_n = ~clk_out_r;
    end else begin
      clk_out_n = clk_out_r;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q           <= '0;
      div_r       <= CNT_W'(DEFAULT_DIV);
      mode_r      <= mode_e'(DEFAULT_MODE);
      // NOTE: the shadow is reset too; it is only a few flops and keeps X
      // out of simulation if PENDING logic is ever changed.
      shadow_div  <= CNT_W'(DEFAULT_DIV);
      shadow_mode <= mode_e'(DEFAULT_MODE);
      pending_r   <= 1'b0;
      clk_out_r   <= 1'b0;
      tick_r      <= 1'b0;
    end else begin
      q           <= q_n;
      div_r       <= div_n;
      mode_r      <= mode_n;
      shadow_div  <= shadow_div_n;
      shadow_mode <= shadow_mode_n;
      pending_r   <= pending_n;
      clk_out_r   <= clk_out_n;
      tick_r      <= tick_n;
    end
  end

  assign CLK_OUT = clk_out_r;
  assign TICK    = tick_r;
  assign PENDING = pending_r;

endmodule

// File: rtl/multi_rate_divider.sv
// NCH-channel programmable clock/tick divider: decodes the load strobe to a
// one-hot write vector and fans it out to independent channels.
module multi_rate_divider
  import div_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int NCH          = 4,
  parameter int DEFAULT_DIV  = 20000,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  SYNC,
  input  logic                  LOAD,
  input  logic [CH_W(NCH)-1:0]  LOAD_CH,
  input  logic [CNT_W-1:0]      LOAD_DIV,
  input  logic                  LOAD_MODE,
  output logic [NCH-1:0]        CLK_OUT,
  output logic [NCH-1:0]        TICK,
  output logic [NCH-1:0]        PENDING
);

  localparam int CW = CH_W(NCH);

  logic [NCH-1:0] wr;

  // Indices at or above NCH match no channel, so such writes are dropped.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (LOAD && (LOAD_CH == CW'(i))) wr[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_MODE(DEFAULT_MODE)
    ) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .EN     (EN),
      .SYNC   (SYNC),
      .WR     (wr[g]),
      .WR_DIV (LOAD_DIV),
      .WR_MODE(LOAD_MODE),
      .CLK_OUT(CLK_OUT[g]),
      .TICK   (TICK[g]),
      .PENDING(PENDING[g])
    );
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Scoreboarded bench for multi_rate_divider: directed scenarios then random
// traffic, checked against a countdown-based behavioural model.
module tb_multi_rate_divider;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int DDIV  = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             SYNC = 1'b0;
  logic             LOAD = 1'b0;
  logic [1:0]       LOAD_CH = '0;
  logic [CNT_W-1:0] LOAD_DIV = '0;
  logic             LOAD_MODE = 1'b0;
  logic [NCH-1:0]   CLK_OUT, TICK, PENDING;

  multi_rate_divider #(
    .CNT_W(CNT_W), .NCH(NCH), .DEFAULT_DIV(DDIV), .DEFAULT_MODE(1'b0)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .LOAD(LOAD),
    .LOAD_CH(LOAD_CH), .LOAD_DIV(LOAD_DIV), .LOAD_MODE(LOAD_MODE),
    .CLK_OUT(CLK_OUT), .TICK(TICK), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int             cyc;
    string          tag;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string tag      = "reset";

  // Model: to_go counts cycles left before the next terminal count.
  int to_go   [NCH];
  int m_div   [NCH];
  bit m_mode  [NCH];
  bit has_sh  [NCH];
  int sh_div  [NCH];
  bit sh_mode [NCH];
  bit lvl     [NCH];
  bit tk      [NCH];

  task automatic model_step();
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      bit wr, fire;
      wr = LOAD && (LOAD_CH == 2'(c));
      if (RST) begin
        m_div[c] = DDIV; m_mode[c] = 1'b0; to_go[c] = DDIV;
        has_sh[c] = 1'b0; lvl[c] = 1'b0; tk[c] = 1'b0;
      end else if (SYNC) begin
        if (wr) begin m_div[c] = int'(LOAD_DIV); m_mode[c] = LOAD_MODE; end
        else if (has_sh[c]) begin m_div[c] = sh_div[c]; m_mode[c] = sh_mode[c]; end
        has_sh[c] = 1'b0; to_go[c] = m_div[c]; lvl[c] = 1'b0; tk[c] = 1'b0;
      end else begin
        fire = EN && (to_go[c] == 0);
        if (fire) begin
          if (wr) begin m_div[c] = int'(LOAD_DIV); m_mode[c] = LOAD_MODE; end
          else if (has_sh[c]) begin m_div[c] = sh_div[c]; m_mode[c] = sh_mode[c]; end
          has_sh[c] = 1'b0;
          to_go[c]  = m_div[c];
        end else begin
          if (EN) to_go[c]--;
          if (wr) begin sh_div[c] = int'(LOAD_DIV); sh_mode[c] = LOAD_MODE; has_sh[c] = 1'b1; end
        end
        tk[c] = fire;
        if (m_mode[c]) lvl[c] = fire;
        else if (fire) lvl[c] = ~lvl[c];
      end
      e.clk_out[c] = lvl[c];
      e.tick[c]    = tk[c];
      e.pending[c] = has_sh[c];
    end
    e.cyc = cyc;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge; one-shot strobes self-clear.
  task automatic cycle_once();
    @(negedge CLK);
    model_step();
    cyc++;
    @(posedge CLK);
    #2;
    LOAD = 1'b0;
    SYNC = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_once();
  endtask

  task automatic do_load(input int ch, input int d, input bit m);
    LOAD = 1'b1; LOAD_CH = 2'(ch); LOAD_DIV = CNT_W'(d); LOAD_MODE = m;
  endtask

  task automatic check(input string name, input logic [NCH-1:0] got,
                       input logic [NCH-1:0] want, input exp_t e);
    n_checks++;
    if (got === want) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s %s cyc=%0d got=%b want=%b", e.tag, name, e.cyc, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; pop and compare after each edge.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("clk_out", CLK_OUT, e.clk_out, e);
      check("tick",    TICK,    e.tick,    e);
      check("pending", PENDING, e.pending, e);
    end
  end

  initial begin
    logic [2:0] bad_ch;
    int         waited;

    run(2);
    RST = 1'b0; EN = 1'b1;
    tag = "s1_toggle";
    run(20);

    tag = "s2_pend_pulse";
    waited = 0;
    while (to_go[1] != 2 && waited < 20) begin run(1); waited++; end
    do_load(1, 1, 1'b1);
    run(12);

    tag = "s3_bypass";
    waited = 0;
    while (to_go[2] != 0 && waited < 20) begin run(1); waited++; end
    do_load(2, 0, 1'b0);
    run(10);

    tag = "s4_en_low";
    run(2);
    EN = 1'b0;
    run(5);
    EN = 1'b1;
    run(12);

    tag = "s5_sync";
    waited = 0;
    while (to_go[3] == 0 && waited < 20) begin run(1); waited++; end
    do_load(3, 7, 1'b0);
    run(1);
    SYNC = 1'b1;
    run(20);

    tag = "s6_rst";
    waited = 0;
    while (to_go[0] == 0 && waited < 20) begin run(1); waited++; end
    do_load(0, 5, 1'b0);
    run(1);
    bad_ch = 3'd5;
    RST = 1'b1;
    do_load(0, 9, 1'b1);
    LOAD_CH = bad_ch[1:0];
    run(1);
    RST = 1'b0;
    run(16);

    tag = "random";
    for (int i = 0; i < 2000; i++) begin
      EN   = ($urandom_range(0, 9) != 0);
      SYNC = ($urandom_range(0, 99) == 0);
      RST  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0)
        do_load($urandom_range(0, NCH - 1), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      cycle_once();
    end
    RST = 1'b0;

    run(2);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
